// File: rtl/multdiv_arbiter.sv
// Two-requester front end for a shared, multi-cycle multiply/divide unit.
// A round-robin arbiter accepts one operation at a time into holding
// registers, drives the unit until it returns a result, and then presents
// that result until the requester takes it. A kill abandons the in-flight
// operation. If the unit is still busy, the kill waits for the unit to
// finish so that the unit is left idle.
module multdiv_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    input  logic [1:0][1:0]        req_op_i,
    input  logic [1:0][1:0]        req_signed_i,
    input  logic [1:0][DATA_W-1:0] req_a_i,
    input  logic [1:0][DATA_W-1:0] req_b_i,
    input  logic                   kill_i,
    input  logic                   data_ind_timing_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_id_o,
    output logic [DATA_W-1:0]      rsp_data_o,
    output logic                   md_mult_en_o,
    output logic                   md_div_en_o,
    output logic                   md_mult_sel_o,
    output logic                   md_div_sel_o,
    output logic [1:0]             md_operator_o,
    output logic [1:0]             md_signed_mode_o,
    output logic [DATA_W-1:0]      md_op_a_o,
    output logic [DATA_W-1:0]      md_op_b_o,
    output logic                   md_ready_id_o,
    output logic                   md_data_ind_timing_o,
    input  logic                   md_valid_i,
    input  logic [DATA_W-1:0]      md_result_i,
    output logic [15:0]            perf_cycles_o
);

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_e;

    state_e             state_q;
    logic               last_grant_q;
    logic               grant;
    logic               accept;
    logic               drive_unit;
    logic               hold_id_q;
    logic [1:0]         hold_op_q;
    logic [1:0]         hold_sm_q;
    logic [DATA_W-1:0]  hold_a_q;
    logic [DATA_W-1:0]  hold_b_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   perf_q;

    // Saturating increment for the BUSY cycle counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Round-robin pick: on a tie take the index that did not win last time
    always_comb begin
        grant = 1'b0;
        if (req_valid_i == 2'b11) begin
            grant = ~last_grant_q;
        end else if (req_valid_i[1] && !req_valid_i[0]) begin
            grant = 1'b1;
        end
    end

    // Ready only toward the granted requester, and only while idle
    always_comb begin
        req_ready_o = 2'b00;
        if (state_q == IDLE && !rst_i) begin
            req_ready_o[grant] = req_valid_i[grant];
        end
    end

    assign accept     = |(req_valid_i & req_ready_o);
    assign drive_unit = (state_q == BUSY) || (state_q == DRAIN);

    // Unit enables follow the held operator class while the unit owns the op
    always_comb begin
        md_mult_en_o  = drive_unit && !hold_op_q[1];
        md_mult_sel_o = drive_unit && !hold_op_q[1];
        md_div_en_o   = drive_unit &&  hold_op_q[1];
        md_div_sel_o  = drive_unit &&  hold_op_q[1];
        md_ready_id_o = drive_unit;
    end

    assign md_operator_o        = hold_op_q;
    assign md_signed_mode_o     = hold_sm_q;
    assign md_op_a_o            = hold_a_q;
    assign md_op_b_o            = hold_b_q;
    assign md_data_ind_timing_o = data_ind_timing_i;
    assign rsp_valid_o          = (state_q == RESP);
    assign rsp_id_o             = hold_id_q;
    assign rsp_data_o           = rsp_data_q;
    assign perf_cycles_o        = perf_q;

    // Control FSM with holding, result and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            hold_id_q    <= 1'b0;
            hold_op_q    <= '0;
            hold_sm_q    <= '0;
            hold_a_q     <= '0;
            hold_b_q     <= '0;
            rsp_data_q   <= '0;
            cnt_q        <= '0;
            perf_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        hold_id_q    <= grant;
                        hold_op_q    <= req_op_i[grant];
                        hold_sm_q    <= req_signed_i[grant];
                        hold_a_q     <= req_a_i[grant];
                        hold_b_q     <= req_b_i[grant];
                        last_grant_q <= grant;
                        cnt_q        <= '0;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= sat_inc(cnt_q);
                    if (md_valid_i && kill_i) begin
                        state_q <= IDLE;
                    end else if (md_valid_i) begin
                        // perf counts every BUSY cycle, including this one
                        rsp_data_q <= md_result_i;
                        perf_q     <= sat_inc(cnt_q);
                        state_q    <= RESP;
                    end else if (kill_i) begin
                        state_q <= DRAIN;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    if (md_valid_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Bench for multdiv_arbiter: a behavioural mult/div unit with a programmable
// latency, directed scenarios followed by a randomized phase, and a
// scoreboard monitor that predicts grants, responses, latency and perf.
module tb_multdiv_arbiter;

    logic             clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][1:0]  req_op;
    logic [1:0][1:0]  req_signed;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic             kill;
    logic             dit;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [31:0]      rsp_data;
    logic             md_mult_en, md_div_en, md_mult_sel, md_div_sel;
    logic [1:0]       md_operator, md_signed_mode;
    logic [31:0]      md_op_a, md_op_b;
    logic             md_ready_id;
    logic             md_dit;
    logic             md_valid;
    logic [31:0]      md_result;
    logic [15:0]      perf;

    multdiv_arbiter #(.DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_signed_i(req_signed),
        .req_a_i(req_a), .req_b_i(req_b),
        .kill_i(kill), .data_ind_timing_i(dit),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
        .md_mult_en_o(md_mult_en), .md_div_en_o(md_div_en),
        .md_mult_sel_o(md_mult_sel), .md_div_sel_o(md_div_sel),
        .md_operator_o(md_operator), .md_signed_mode_o(md_signed_mode),
        .md_op_a_o(md_op_a), .md_op_b_o(md_op_b),
        .md_ready_id_o(md_ready_id), .md_data_ind_timing_o(md_dit),
        .md_valid_i(md_valid), .md_result_i(md_result),
        .perf_cycles_o(perf)
    );

    // Reference arithmetic: MULL/MULH on 33-bit extended operands, DIV/REM
    // with the usual divide-by-zero and signed-overflow results.
    function automatic logic [31:0] ref_calc(input logic [1:0] op, input logic [1:0] sm,
                                             input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] xa, xb;
        logic signed [65:0] prod;
        logic signed [31:0] sa, sb;
        logic [31:0]        r;
        xa = {sm[0] & a[31], a};
        xb = {sm[1] & b[31], b};
        prod = xa * xb;
        sa = a;
        sb = b;
        if (op == 2'd0) r = prod[31:0];
        else if (op == 2'd1) r = prod[63:32];
        else if (b == 32'd0) r = (op == 2'd2) ? 32'hFFFF_FFFF : a;
        else if (sm == 2'b11) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = (op == 2'd2) ? a : 32'd0;
            else if (op == 2'd2) r = sa / sb;
            else r = sa % sb;
        end
        else if (op == 2'd2) r = a / b;
        else r = a % b;
        return r;
    endfunction

    function automatic logic mgrant(input logic [1:0] v, input logic last);
        if (v == 2'b11) return ~last;
        if (v[0]) return 1'b0;
        return 1'b1;
    endfunction

    // Behavioural unit: result valid on the unit_lat-th enabled cycle
    int unit_lat = 3;
    int ucnt = 0;
    always_comb begin
        md_valid  = (md_mult_en || md_div_en) && (ucnt == unit_lat - 1);
        md_result = 32'd0;
        if (md_valid) md_result = ref_calc(md_operator, md_signed_mode, md_op_a, md_op_b);
    end
    always @(posedge clk) begin
        if (rst || !(md_mult_en || md_div_en) || md_valid) ucnt <= 0;
        else ucnt <= ucnt + 1;
    end

    int cyc = 0;
    bit rst_d = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          acc;
        int          lat;
    } exp_t;
    exp_t q[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          acc_total = 0;
    int          stim_to = 0;
    bit          inflight = 1'b0;
    bit          killed = 1'b0;
    bit          rsp_first = 1'b0;
    bit          done_req = 1'b0;
    bit          fin = 1'b0;
    logic        mlast = 1'b1;
    int          cur_acc, cur_lat;
    logic [1:0]  cur_op, cur_sm;
    logic [31:0] cur_a, cur_b;
    logic        h_id;
    logic [31:0] h_data;
    logic [1:0]  eg;
    logic        gid;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (rst_d) begin
            check("rst_ctrl", 64'({rsp_valid, rsp_id, md_mult_en, md_div_en, md_mult_sel,
                                   md_div_sel, md_ready_id}), 64'd0);
            check("rst_data", 64'(rsp_data), 64'd0);
            check("rst_perf", 64'(perf), 64'd0);
            check("rst_ops", {md_op_a, md_op_b}, 64'd0);
            check("rst_mode", 64'({md_operator, md_signed_mode}), 64'd0);
        end
        if (rst) begin
            check("rst_ready", 64'(req_ready), 64'd0);
            q.delete();
            inflight  = 1'b0;
            killed    = 1'b0;
            rsp_first = 1'b0;
            mlast     = 1'b1;
        end else begin
            eg = 2'b00;
            if (!inflight && req_valid != 2'b00) eg = mgrant(req_valid, mlast) ? 2'b10 : 2'b01;
            if (req_valid != 2'b00 || req_ready != 2'b00) check("grant", 64'(req_ready), 64'(eg));
            if (!inflight && (req_valid & req_ready) != 2'b00) begin
                gid = req_ready[1];
                q.push_back('{id: gid,
                              data: ref_calc(req_op[gid], req_signed[gid], req_a[gid], req_b[gid]),
                              acc: cyc, lat: unit_lat});
                cur_acc = cyc;
                cur_lat = unit_lat;
                cur_op  = req_op[gid];
                cur_sm  = req_signed[gid];
                cur_a   = req_a[gid];
                cur_b   = req_b[gid];
                inflight = 1'b1;
                killed   = 1'b0;
                mlast    = gid;
                acc_total++;
                check("dit_pass", 64'(md_dit), 64'(dit));
            end else begin
                if (kill && inflight && !killed && cyc >= cur_acc + 1 && cyc <= cur_acc + cur_lat) begin
                    killed = 1'b1;
                    if (q.size() > 0) q.delete(0);
                end
                if (inflight && md_valid) begin
                    check("unit_en", 64'({md_mult_en, md_mult_sel, md_div_en, md_div_sel, md_ready_id}),
                          cur_op[1] ? 64'b00111 : 64'b11001);
                    check("unit_a", 64'(md_op_a), 64'(cur_a));
                    check("unit_b", 64'(md_op_b), 64'(cur_b));
                    check("unit_mode", 64'({md_operator, md_signed_mode}), 64'({cur_op, cur_sm}));
                end
                if (rsp_valid) begin
                    check("rsp_unit_idle", 64'({md_mult_en, md_div_en, md_mult_sel, md_div_sel, md_ready_id}), 64'd0);
                    if (!inflight || killed || q.size() == 0) begin
                        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                    end else begin
                        if (!rsp_first) begin
                            rsp_first = 1'b1;
                            h_id   = rsp_id;
                            h_data = rsp_data;
                            check("rsp_latency", 64'(cyc - cur_acc), 64'(cur_lat + 1));
                            check("rsp_id", 64'(rsp_id), 64'(q[0].id));
                            check("rsp_data", 64'(rsp_data), 64'(q[0].data));
                            check("perf", 64'(perf), 64'(q[0].lat));
                        end else begin
                            check("rsp_hold", 64'({h_id, h_data}), 64'({rsp_id, rsp_data}));
                        end
                        if (rsp_ready) begin
                            q.delete(0);
                            inflight  = 1'b0;
                            rsp_first = 1'b0;
                        end
                    end
                end
                if (inflight && killed && cyc >= cur_acc + cur_lat) inflight = 1'b0;
            end
        end
        if (done_req && !fin) begin
            check("queue_empty", 64'(q.size()), 64'd0);
            check("stim_timeouts", 64'(stim_to), 64'd0);
            fin = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [1:0] sg,
                           input logic [31:0] a, input logic [31:0] b);
        req_op[id]     = op;
        req_signed[id] = sg;
        req_a[id]      = a;
        req_b[id]      = b;
    endtask

    task automatic wait_acc(input int n);
        int start;
        int t;
        start = acc_total;
        t = 0;
        while (acc_total < start + n && t < 300) begin
            tick();
            t++;
        end
        if (t >= 300) stim_to++;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            tick();
            t++;
        end while (inflight && t < 400);
        if (t >= 400) stim_to++;
    endtask

    task automatic issue(input int id, input logic [1:0] op, input logic [1:0] sg,
                         input logic [31:0] a, input logic [31:0] b, input int lat);
        unit_lat = lat;
        set_req(id, op, sg, a, b);
        req_valid[id] = 1'b1;
        wait_acc(1);
        req_valid[id] = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_req(input int id);
        logic [1:0] op;
        op = 2'($urandom_range(0, 3));
        set_req(id, op, op[1] ? ($urandom_range(0, 1) != 0 ? 2'b11 : 2'b00) : 2'($urandom_range(0, 3)),
                pick(), pick());
    endtask

    initial begin
        int prev_acc;
        int t;
        rst = 1'b1;
        req_valid = 2'b00;
        req_op = '0;
        req_signed = '0;
        req_a = '0;
        req_b = '0;
        kill = 1'b0;
        dit = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Tie in the first cycle after reset: grants 0, then 1, 0, 1
        unit_lat = 3;
        set_req(0, 2'd1, 2'b11, 32'h8000_0000, 32'd2);
        set_req(1, 2'd2, 2'b11, 32'd5, 32'd0);
        req_valid = 2'b11;
        wait_acc(4);
        req_valid = 2'b00;
        wait_idle();

        issue(0, 2'd0, 2'b00, 32'd7, 32'd6, 4);
        wait_idle();
        issue(1, 2'd2, 2'b11, 32'hFFFF_FFEC, 32'd3, 6);
        wait_idle();
        issue(1, 2'd3, 2'b11, 32'hFFFF_FFEC, 32'd3, 5);
        wait_idle();

        // Kill a long divide five cycles after accept
        issue(0, 2'd2, 2'b00, 32'd100, 32'd7, 12);
        repeat (4) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        wait_idle();
        issue(0, 2'd0, 2'b00, 32'd3, 32'd3, 2);
        wait_idle();

        // Held response with a competing request pending
        rsp_ready = 1'b0;
        issue(1, 2'd0, 2'b00, 32'h1234, 32'h10, 2);
        set_req(0, 2'd0, 2'b00, 32'd5, 32'd5);
        req_valid[0] = 1'b1;
        repeat (14) tick();
        rsp_ready = 1'b1;
        wait_acc(1);
        req_valid[0] = 1'b0;
        wait_idle();

        // Reset in the middle of a divide
        issue(1, 2'd2, 2'b00, 32'd1000, 32'd7, 20);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue(0, 2'd0, 2'b00, 32'd2, 32'd5, 3);
        wait_idle();

        // Randomized traffic with random kills, back-pressure and latency
        prev_acc = acc_total;
        for (int n = 0; n < 3000; n++) begin
            if (!inflight) unit_lat = $urandom_range(1, 8);
            for (int id = 0; id < 2; id++) begin
                if (acc_total != prev_acc && int'(mlast) == id) begin
                    rand_req(id);
                    req_valid[id] = ($urandom_range(0, 1) != 0);
                end else if (!req_valid[id]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rand_req(id);
                        req_valid[id] = 1'b1;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[id] = 1'b0;
                end
            end
            prev_acc  = acc_total;
            rsp_ready = ($urandom_range(0, 3) != 0);
            kill      = ($urandom_range(0, 24) == 0);
            dit       = 1'($urandom_range(0, 1));
            tick();
        end
        req_valid = 2'b00;
        kill = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        done_req = 1'b1;
        t = 0;
        while (!fin && t < 10) begin
            tick();
            t++;
        end
        if (!fin) $display("FAIL finish: monitor did not close the run");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
